// File: rtl/nibble_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : nibble_sum_accumulator
// Purpose  : Consumes the nibble-adder sum stream over valid/ready, keeps a
//            saturating running total and sample count, and on request
//            shifts a {start, total, count} snapshot out as one serial frame.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous active-high reset
//   sum_in     in   SUM_W  unsigned sum from the adder stage
//   sum_valid  in   1      sum_in valid this cycle
//   sum_ready  out  1      block can accept a sum (high in ACCUM)
//   clear      in   1      synchronous clear of total, count and ovf
//   dump_req   in   1      request a serial snapshot frame
//   acc_out    out  ACC_W  running total (saturating)
//   count_out  out  CNT_W  accepted-sample count (saturating)
//   ovf        out  1      sticky total-saturation flag
//   ser_out    out  1      serial frame data, MSB first
//   ser_active out  1      high while a frame is on ser_out
// ============================================================================
module nibble_sum_accumulator #(
  parameter int SUM_W = 4,
  parameter int ACC_W = 12,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SUM_W-1:0] sum_in,
  input  logic             sum_valid,
  output logic             sum_ready,
  input  logic             clear,
  input  logic             dump_req,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] count_out,
  output logic             ovf,
  output logic             ser_out,
  output logic             ser_active
);

  localparam int FRAME_W   = 1 + ACC_W + CNT_W;
  localparam int BIT_CNT_W = $clog2(FRAME_W);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_W - 1);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DUMP  = 1'b1
  } state_t;

  state_t               state_q,      state_d;
  logic [ACC_W-1:0]     acc_q,        acc_d;
  logic [CNT_W-1:0]     count_q,      count_d;
  logic                 ovf_q,        ovf_d;
  logic [FRAME_W-1:0]   shift_q,      shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q,    bit_cnt_d;
  logic                 ser_active_q, ser_active_d;

  // One extra bit so the carry out of the add flags saturation.
  logic [ACC_W:0] acc_sum;
  assign acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(sum_in);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    count_d      = count_q;
    ovf_d        = ovf_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    ser_active_d = ser_active_q;

    case (state_q)
      ST_ACCUM: begin
        ser_active_d = 1'b0;
        if (clear) begin
          // Clear wins over a same-cycle sample and dump request.
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end else begin
          if (sum_valid) begin
            if (acc_sum[ACC_W]) begin
              acc_d = '1;
              ovf_d = 1'b1;
            end else begin
              acc_d = acc_sum[ACC_W-1:0];
            end
            if (count_q != '1) begin
              count_d = count_q + CNT_W'(1);
            end
          end
          if (dump_req) begin
            // Snapshot includes a sample accepted on this same edge.
            shift_d      = {1'b1, acc_d, count_d};
            bit_cnt_d    = '0;
            ser_active_d = 1'b1;
            state_d      = ST_DUMP;
          end
        end
      end

      ST_DUMP: begin
        if (bit_cnt_q == LAST_BIT) begin
          shift_d      = '0;
          bit_cnt_d    = '0;
          ser_active_d = 1'b0;
          state_d      = ST_ACCUM;
        end else begin
          shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_ACCUM;
      acc_q        <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      ser_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      ser_active_q <= ser_active_d;
    end
  end

  // The shift register MSB is the serial pin; it is zero outside a frame.
  assign ser_out    = shift_q[FRAME_W-1];
  assign ser_active = ser_active_q;
  assign sum_ready  = (state_q == ST_ACCUM);
  assign acc_out    = acc_q;
  assign count_out  = count_q;
  assign ovf        = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_sum_accumulator
// Purpose  : Directed self-checking bench for nibble_sum_accumulator with a
//            behavioural reference model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_sum_accumulator;

  localparam int SUM_W   = 4;
  localparam int ACC_W   = 12;
  localparam int CNT_W   = 8;
  localparam int F       = 1 + ACC_W + CNT_W;
  localparam int ACC_MAX = (1 << ACC_W) - 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic [SUM_W-1:0] sum_in;
  logic             sum_valid;
  logic             sum_ready;
  logic             clear;
  logic             dump_req;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] count_out;
  logic             ovf;
  logic             ser_out;
  logic             ser_active;

  int errors = 0;
  int checks = 0;
  logic check_en = 1'b0;

  nibble_sum_accumulator #(.SUM_W(SUM_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .sum_in     (sum_in),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .clear      (clear),
    .dump_req   (dump_req),
    .acc_out    (acc_out),
    .count_out  (count_out),
    .ovf        (ovf),
    .ser_out    (ser_out),
    .ser_active (ser_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_fpos < 0 : accumulating; otherwise index of the frame bit on the pin.
  logic [31:0]  m_acc;
  logic [31:0]  m_cnt;
  logic         m_ovf;
  int           m_fpos;
  logic [F-1:0] m_frame;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_acc = 0; m_cnt = 0; m_ovf = 0; m_fpos = -1; m_frame = '0;
    end else if (m_fpos >= 0) begin
      if (m_fpos == F - 1) m_fpos = -1;
      else m_fpos = m_fpos + 1;
    end else if (clear) begin
      m_acc = 0; m_cnt = 0; m_ovf = 0;
    end else begin
      if (sum_valid) begin
        if (m_acc + sum_in > ACC_MAX) begin
          m_acc = ACC_MAX; m_ovf = 1;
        end else begin
          m_acc = m_acc + sum_in;
        end
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end
      if (dump_req) begin
        m_frame = {1'b1, m_acc[ACC_W-1:0], m_cnt[CNT_W-1:0]};
        m_fpos  = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      chk("acc_out",    acc_out,    m_acc);
      chk("count_out",  count_out,  m_cnt);
      chk("ovf",        ovf,        m_ovf);
      chk("sum_ready",  sum_ready,  m_fpos < 0);
      chk("ser_active", ser_active, m_fpos >= 0);
      chk("ser_out",    ser_out,    (m_fpos >= 0) ? m_frame[F-1-m_fpos] : 1'b0);
    end
  end

  // ---------------- frame capture monitor ----------------
  logic [F-1:0] cap;
  int act_cnt, nready_cnt, frames;
  logic prev_active = 1'b0;

  always @(negedge clk) begin
    if (ser_active) begin
      cap     <= {cap[F-2:0], ser_out};
      act_cnt <= act_cnt + 1;
      if (!prev_active) frames <= frames + 1;
    end
    if (!sum_ready) nready_cnt <= nready_cnt + 1;
    prev_active <= ser_active;
  end

  // Only called while the block is idle so the monitor adds nothing then.
  task automatic zero_mon();
    cap = '0; act_cnt = 0; nready_cnt = 0; frames = 0;
  endtask

  task automatic step(input logic v, input logic [SUM_W-1:0] val,
                      input logic c, input logic d);
    sum_valid = v; sum_in = val; clear = c; dump_req = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; sum_valid = 0; sum_in = 0; clear = 0; dump_req = 0;
    zero_mon();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_en = 1'b1;

    // Reset in the middle of accumulating, then 3 + 5.
    step(1, 4'd7, 0, 0);
    step(1, 4'd7, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("rst_acc",   acc_out,    0);
    chk("rst_cnt",   count_out,  0);
    chk("rst_ovf",   ovf,        0);
    chk("rst_ready", sum_ready,  1);
    chk("rst_act",   ser_active, 0);
    chk("rst_ser",   ser_out,    0);
    @(negedge clk);
    reset = 1'b0;
    step(1, 4'd3, 0, 0);
    step(1, 4'd5, 0, 0);
    chk("add_acc", acc_out,   8);
    chk("add_cnt", count_out, 2);
    chk("add_ovf", ovf,       0);

    // Saturation of both total and count.
    step(0, 0, 1, 0);
    for (int i = 0; i < 300; i++) step(1, 4'd15, 0, 0);
    chk("sat_acc", acc_out,   4095);
    chk("sat_cnt", count_out, 255);
    chk("sat_ovf", ovf,       1);
    step(1, 4'd0, 0, 0);
    chk("sat_ovf_sticky", ovf,     1);
    chk("sat_acc_hold",   acc_out, 4095);

    // Dump frame of acc = 0x0A5 (11 x 15), count = 0x13 (19 samples).
    step(0, 0, 1, 0);
    for (int i = 0; i < 11; i++) step(1, 4'd15, 0, 0);
    for (int i = 0; i < 8; i++)  step(1, 4'd0, 0, 0);
    chk("pre_acc", acc_out,   12'h0A5);
    chk("pre_cnt", count_out, 8'h13);
    zero_mon();
    step(0, 0, 0, 1);
    idle(24);
    chk("frame_bits",  cap,        {1'b1, 12'h0A5, 8'h13});
    chk("frame_len",   act_cnt,    21);
    chk("ready_low",   nready_cnt, 21);
    chk("frame_count", frames,     1);

    // Accept and dump on the same edge.
    step(0, 0, 1, 0);
    step(1, 4'd10, 0, 0);
    zero_mon();
    step(1, 4'd4, 0, 1);
    idle(24);
    chk("simul_bits", cap, {1'b1, 12'd14, 8'd2});

    // Inputs ignored during a frame.
    zero_mon();
    step(0, 0, 0, 1);
    idle(3);
    for (int i = 0; i < 5; i++) step(1, 4'd7, 1, 1);
    idle(20);
    chk("iso_acc",    acc_out,   14);
    chk("iso_cnt",    count_out, 2);
    chk("iso_frames", frames,    1);
    chk("iso_len",    act_cnt,   21);
    step(1, 4'd9, 1, 0);
    chk("clr_acc", acc_out,    0);
    chk("clr_cnt", count_out,  0);
    chk("clr_ovf", ovf,        0);
    chk("clr_act", ser_active, 0);
    step(0, 0, 1, 1);
    chk("clr_drops_dump", ser_active, 0);

    // Held dump_req: back-to-back frames with a one-cycle gap.
    step(1, 4'd6, 0, 0);
    zero_mon();
    for (int i = 0; i < 23; i++) step(0, 0, 0, 1);
    idle(25);
    chk("b2b_frames", frames,  2);
    chk("b2b_len",    act_cnt, 42);

    // Reset while bit 10 of a frame is on the pin.
    step(1, 4'd9, 0, 0);
    step(0, 0, 0, 1);
    idle(10);
    #2 reset = 1'b1;
    #1;
    chk("mrst_act",   ser_active, 0);
    chk("mrst_ser",   ser_out,    0);
    chk("mrst_ready", sum_ready,  1);
    chk("mrst_acc",   acc_out,    0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    chk("post_ready", sum_ready,  1);
    chk("post_acc",   acc_out,    0);
    chk("post_act",   ser_active, 0);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
